control_barrido_display: RTL and testbench
==========================================

// Module: control_barrido_display
// PURPOSE
//  Scan scheduler for the 8-digit 7-seg display; sequences the anode decode for the signed Booth product.
//  Takes a 5-digit BCD magnitude plus sign over a valid/ready handshake and double-buffers it.
//  Time-multiplexes 6 positions (5 digits + sign) with a dead time between digits to prevent ghosting.
//  Sits between the binary-to-BCD converter and the segment decoder.
// PARAMETERS
//  CLK_HZ          100_000_000  system clock frequency
//  TICK_HZ         10_000       digit-slot rate; DIV = CLK_HZ/TICK_HZ cycles per slot
//  CICLOS_APAGADO  100          all-anodes-off cycles at the start of each slot; must be < DIV
//  SUPRIMIR_CEROS  1            1 = blank leading zeros on digits 4..1
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active low
//  dato_bcd     in   20  magnitude; [3:0] = units ... [19:16] = ten-thousands
//  signo        in   1   1 = negative
//  dato_valido  in   1   dato_bcd/signo are valid
//  dato_listo   out  1   pending buffer is empty; accept occurs when dato_valido && dato_listo
//  anodo        out  8   active-low anode enables; [7:6] are always 1
//  digito_bcd   out  4   nibble for the lit slot: 0-9, 4'hA = minus, 4'hF = blank
//  indice       out  3   current slot, 0..5
//  fin_trama    out  1   1-cycle pulse at the slot 5 -> 0 transition
// BEHAVIOUR
//  Clock and reset
//   - One clock. Reset is asynchronous and active low.
//   - Reset values: anodo=8'hFF, digito_bcd=4'hF, indice=0, fin_trama=0, dato_listo=1, FSM=ESPERA.
//   - Reset also clears the active and pending buffers and the prescaler.
//  Registers
//   - All outputs are registered and update on the same edge as FSM state and indice.
//  Buffers
//   - Two buffers: pendiente (written by the handshake) and activo (displayed).
//   - Accept: pendiente <= {signo, dato_bcd}; lleno=1. dato_listo = !lleno, so it drops one cycle after accept.
//   - Transfer (lleno=1 only):
//     * at the slot 5->0 edge: activo <= pendiente, lleno=0, dato_listo=1 on the next cycle;
//     * or in ESPERA, on the cycle after accept.
//   - An accept and a transfer cannot coincide: accept needs lleno=0, transfer needs lleno=1.
//   - dato_valido while dato_listo=0 is ignored. The upstream holds its data; no overwrite.
//   - No BCD check on the data: nibbles >9 pass through unchanged.
//  FSM
//   - ESPERA: anodo=FF. Exit on transfer -> APAGADO with indice=0 and prescaler=0.
//   - APAGADO: anodo=FF, digito_bcd=F, for CICLOS_APAGADO cycles, then -> ENCENDIDO.
//   - ENCENDIDO: drive the slot for the remaining DIV-CICLOS_APAGADO cycles.
//     At the end of the slot: -> APAGADO, indice = (indice==5) ? 0 : indice+1.
//   - Prescaler counts 0..DIV-1 and wraps; each slot is exactly DIV cycles.
//  Slot content
//   - Slots 0..4: anodo bit i low, digito_bcd = nibble i.
//   - Blanking (SUPRIMIR_CEROS=1): slot i in 1..4 is blank if nibble i and all higher nibbles are 0.
//     Blank slot: anodo=FF, digito_bcd=F. Slot 0 is never blanked.
//   - Slot 5: signo=1 and magnitude!=0 -> anodo=8'hDF, digito_bcd=A. Otherwise blank.
//  Framing
//   - Frame = 6*DIV cycles. fin_trama pulses once per frame.
//   - Reset mid-slot forces the reset values immediately; the display returns to ESPERA.
// TESTING  (sim params: CLK_HZ=1000, TICK_HZ=100 -> DIV=10, CICLOS_APAGADO=2)
//  1. Reset, no valid for 200 cycles -> anodo=FF, digito_bcd=F, dato_listo=1 throughout.
//  2. Load 20'h12345, signo=0.
//     -> slots 0..4 show 5,4,3,2,1: FE,FD,FB,F7,EF, each 2 cycles FF then 8 lit.
//     -> slot 5 blank; fin_trama every 60 cycles.
//  3. Load 20'h00070, signo=1 -> slot0=0 (FE), slot1=7 (FD), slots 2-4 FF/F, slot5 A on DF.
//  4. Load 20'h00000, signo=1 -> only slot0 shows 0; sign slot blank.
//  5. Load 20'h11111 at slot 2 of a 20'h22222 frame.
//     -> dato_listo=0; 2s shown until fin_trama, then 1s from slot 0.
//     -> dato_listo=1 the cycle after transfer; a second valid held during the wait is accepted only then.
//  6. Assert rst_n=0 mid-ENCENDIDO -> anodo=FF the same cycle; after release, FF in ESPERA until a new load.

Source files
------------

// File: rtl/control_barrido_display.sv
// Scan scheduler for a multiplexed 7-segment display: double-buffered BCD magnitude plus sign,
// six time slots (five digits and a minus sign) with an all-off dead time at the start of each slot.
module control_barrido_display #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 10_000,
    parameter int CICLOS_APAGADO = 100,
    parameter int SUPRIMIR_CEROS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] dato_bcd,
    input  logic        signo,
    input  logic        dato_valido,
    output logic        dato_listo,
    output logic [7:0]  anodo,
    output logic [3:0]  digito_bcd,
    output logic [2:0]  indice,
    output logic        fin_trama
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] APAG_FIN  = PW'(CICLOS_APAGADO);

    localparam logic [1:0] ESPERA    = 2'd0;
    localparam logic [1:0] APAGADO   = 2'd1;
    localparam logic [1:0] ENCENDIDO = 2'd2;

    logic [1:0]    estado_q, estado_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    indice_q, indice_d;
    logic [20:0]   activo_q, activo_d;
    logic [20:0]   pendiente_q, pendiente_d;
    logic          lleno_q, lleno_d;
    logic [7:0]    anodo_q, anodo_d;
    logic [3:0]    digito_q, digito_d;
    logic          fin_trama_q, fin_trama_d;

    logic          aceptar;
    logic          fin_slot;
    logic [19:0]   mag;
    logic [7:0]    blanco;

    // The dead time and the lit time of a slot are both positions of the same prescaler.
    function automatic logic [1:0] fase(input logic [PW-1:0] p);
        return (p < APAG_FIN) ? APAGADO : ENCENDIDO;
    endfunction

    assign aceptar  = dato_valido && !lleno_q;
    assign fin_slot = (presc_q == PRESC_MAX);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        estado_d    = estado_q;
        presc_d     = presc_q;
        indice_d    = indice_q;
        activo_d    = activo_q;
        pendiente_d = pendiente_q;
        lleno_d     = lleno_q;
        fin_trama_d = 1'b0;

        if (aceptar) begin
            pendiente_d = {signo, dato_bcd};
            lleno_d     = 1'b1;
        end

        if (estado_q == ESPERA) begin
            if (lleno_q) begin
                activo_d = pendiente_q;
                lleno_d  = 1'b0;
                presc_d  = '0;
                indice_d = 3'd0;
                estado_d = fase('0);
            end
        end else begin
            if (fin_slot) begin
                presc_d = '0;
                if (indice_q == 3'd5) begin
                    indice_d    = 3'd0;
                    fin_trama_d = 1'b1;
                    // New data only swaps in between frames so a frame is never mixed.
                    if (lleno_q) begin
                        activo_d = pendiente_q;
                        lleno_d  = 1'b0;
                    end
                end else begin
                    indice_d = indice_q + 3'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
            estado_d = fase(presc_d);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as indice.
    always_comb begin
        mag      = activo_d[19:0];
        anodo_d  = 8'hFF;
        digito_d = 4'hF;
        for (int i = 0; i < 8; i++) begin
            blanco[i] = (SUPRIMIR_CEROS != 0) && (i >= 1) && (i <= 4) &&
                        ((mag >> (4 * i)) == 20'd0);
        end

        if (estado_d == ENCENDIDO) begin
            if (indice_d <= 3'd4) begin
                if (!blanco[indice_d]) begin
                    anodo_d  = ~(8'b1 << indice_d);
                    digito_d = 4'(mag >> {indice_d, 2'b00});
                end
            end else if (activo_d[20] && (mag != 20'd0)) begin
                anodo_d  = 8'hDF;
                digito_d = 4'hA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= ESPERA;
            presc_q     <= '0;
            indice_q    <= 3'd0;
            activo_q    <= '0;
            pendiente_q <= '0;
            lleno_q     <= 1'b0;
            anodo_q     <= 8'hFF;
            digito_q    <= 4'hF;
            fin_trama_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            estado_q    <= estado_d;
            presc_q     <= presc_d;
            indice_q    <= indice_d;
            activo_q    <= activo_d;
            pendiente_q <= pendiente_d;
            lleno_q     <= lleno_d;
            anodo_q     <= anodo_d;
            digito_q    <= digito_d;
            fin_trama_q <= fin_trama_d;
        end
    end

    assign dato_listo = !lleno_q;
    assign anodo      = anodo_q;
    assign digito_bcd = digito_q;
    assign indice     = indice_q;
    assign fin_trama  = fin_trama_q;

endmodule

// File: tb/tb_control_barrido_display.sv
// Directed bench for control_barrido_display with DIV=10 and a 2-cycle dead time per slot.
module tb_control_barrido_display;

    localparam int DIV = 10;
    localparam int CA  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] dato_bcd;
    logic        signo;
    logic        dato_valido;
    logic        dato_listo;
    logic [7:0]  anodo;
    logic [3:0]  digito_bcd;
    logic [2:0]  indice;
    logic        fin_trama;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    control_barrido_display #(
        .CLK_HZ        (1000),
        .TICK_HZ       (100),
        .CICLOS_APAGADO(2),
        .SUPRIMIR_CEROS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dato_bcd   (dato_bcd),
        .signo      (signo),
        .dato_valido(dato_valido),
        .dato_listo (dato_listo),
        .anodo      (anodo),
        .digito_bcd (digito_bcd),
        .indice     (indice),
        .fin_trama  (fin_trama)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input logic [2:0] idx, input logic [7:0] an,
                               input logic [3:0] dig, input logic fin);
        check("indice", 32'(indice), 32'(idx));
        check("anodo", 32'(anodo), 32'(an));
        check("digito_bcd", 32'(digito_bcd), 32'(dig));
        check("fin_trama", 32'(fin_trama), 32'(fin));
        step();
    endtask

    task automatic check_slot(input logic [2:0] idx, input logic [7:0] an,
                              input logic [3:0] dig, input logic fin_first);
        for (int k = 0; k < DIV; k++) begin
            check_cycle(idx, (k < CA) ? 8'hFF : an, (k < CA) ? 4'hF : dig,
                        (k == 0) ? fin_first : 1'b0);
        end
    endtask

    task automatic check_frame(input logic [47:0] an, input logic [23:0] dig,
                               input logic fin_first);
        for (int s = 0; s < 6; s++) begin
            check_slot(3'(s), an[8*s +: 8], dig[4*s +: 4], (s == 0) ? fin_first : 1'b0);
        end
    endtask

    // Handshake from ESPERA: returns on the first cycle of slot 0 after the transfer edge.
    task automatic load(input logic [19:0] data, input logic sgn);
        dato_bcd    = data;
        signo       = sgn;
        dato_valido = 1'b1;
        check("listo_antes", 32'(dato_listo), 32'd1);
        step();
        dato_valido = 1'b0;
        check("listo_tras_aceptar", 32'(dato_listo), 32'd0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        dato_bcd    = '0;
        signo       = 1'b0;
        dato_valido = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 200; c++) begin
            check("idle_anodo", 32'(anodo), 32'hFF);
            check("idle_digito", 32'(digito_bcd), 32'hF);
            check("idle_listo", 32'(dato_listo), 32'd1);
            check("idle_indice", 32'(indice), 32'd0);
            step();
        end

        // 12345 positive: two frames, fin_trama only at the wrap into the second
        load(20'h12345, 1'b0);
        check_frame({8'hFF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                    {4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5}, 1'b0);
        check_frame({8'hFF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                    {4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5}, 1'b1);

        // -70: leading zeros blanked, minus sign lit
        do_reset();
        load(20'h00070, 1'b1);
        check_frame({8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
                    {4'hA, 4'hF, 4'hF, 4'hF, 4'h7, 4'h0}, 1'b0);

        // -0: only units shown, no sign
        do_reset();
        load(20'h00000, 1'b1);
        check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
                    {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0}, 1'b0);

        // Double buffering: new data accepted mid-frame, shown only from the next frame
        do_reset();
        load(20'h22222, 1'b0);
        check_slot(3'd0, 8'hFE, 4'h2, 1'b0);
        check_slot(3'd1, 8'hFD, 4'h2, 1'b0);
        dato_bcd    = 20'h11111;
        signo       = 1'b0;
        dato_valido = 1'b1;
        check("listo_slot2", 32'(dato_listo), 32'd1);
        check_cycle(3'd2, 8'hFF, 4'hF, 1'b0);
        dato_bcd = 20'h33333;
        for (int k = 1; k < DIV; k++) begin
            check("listo_lleno", 32'(dato_listo), 32'd0);
            check_cycle(3'd2, (k < CA) ? 8'hFF : 8'hFB, (k < CA) ? 4'hF : 4'h2, 1'b0);
        end
        check_slot(3'd3, 8'hF7, 4'h2, 1'b0);
        check_slot(3'd4, 8'hEF, 4'h2, 1'b0);
        check("listo_fin_trama_previo", 32'(dato_listo), 32'd0);
        check_slot(3'd5, 8'hFF, 4'hF, 1'b0);
        check("listo_tras_transfer", 32'(dato_listo), 32'd1);
        check_cycle(3'd0, 8'hFF, 4'hF, 1'b1);
        dato_valido = 1'b0;
        check("listo_segundo_aceptado", 32'(dato_listo), 32'd0);
        for (int k = 1; k < DIV; k++) begin
            check_cycle(3'd0, (k < CA) ? 8'hFF : 8'hFE, (k < CA) ? 4'hF : 4'h1, 1'b0);
        end
        check_slot(3'd1, 8'hFD, 4'h1, 1'b0);
        check_slot(3'd2, 8'hFB, 4'h1, 1'b0);
        check_slot(3'd3, 8'hF7, 4'h1, 1'b0);
        check_slot(3'd4, 8'hEF, 4'h1, 1'b0);
        check_slot(3'd5, 8'hFF, 4'hF, 1'b0);
        check_slot(3'd0, 8'hFE, 4'h3, 1'b1);

        // Asynchronous reset while slot 1 is lit
        check_cycle(3'd1, 8'hFF, 4'hF, 1'b0);
        check_cycle(3'd1, 8'hFF, 4'hF, 1'b0);
        check("lit_before_reset", 32'(anodo), 32'hFD);
        rst_n = 1'b0;
        #1;
        check("rst_anodo", 32'(anodo), 32'hFF);
        check("rst_digito", 32'(digito_bcd), 32'hF);
        check("rst_indice", 32'(indice), 32'd0);
        check("rst_listo", 32'(dato_listo), 32'd1);
        check("rst_fin_trama", 32'(fin_trama), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            check("espera_anodo", 32'(anodo), 32'hFF);
            check("espera_digito", 32'(digito_bcd), 32'hF);
            check("espera_indice", 32'(indice), 32'd0);
            step();
        end

        // Non-BCD nibble passes through unchanged
        load(20'h000B0, 1'b0);
        check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
                    {4'hF, 4'hF, 4'hF, 4'hF, 4'hB, 4'h0}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
